// File: rtl/frame_buffer_arbiter_if.sv
// SDRAM controller command port as seen from the frame buffer arbiter.
//   master : arbiter side (drives cmd_req/cmd_wr/cmd_addr/cmd_len, sees cmd_ack/burst_done)
//   slave  : SDRAM controller side
// cmd_addr is {bank, word offset}.
interface frame_buffer_arbiter_if #(
  parameter int unsigned OFFS_W = 20
) ();
  logic              cmd_req;
  logic              cmd_ack;
  logic              cmd_wr;
  logic [OFFS_W:0]   cmd_addr;
  logic [7:0]        cmd_len;
  logic              burst_done;

  modport master (
    output cmd_req,
    output cmd_wr,
    output cmd_addr,
    output cmd_len,
    input  cmd_ack,
    input  burst_done
  );

  modport slave (
    input  cmd_req,
    input  cmd_wr,
    input  cmd_addr,
    input  cmd_len,
    output cmd_ack,
    output burst_done
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Schedules SDRAM bursts between the camera write FIFO and the display read FIFO and owns the
// double-buffered frame addressing (write/read bank, per-frame word offsets).
// One burst in flight at a time: IDLE -> REQ -> WAIT -> IDLE.
// Ports:
//   CLK, RSTn      clock, asynchronous active-low reset
//   wr_fifo_level  camera FIFO words available
//   rd_fifo_level  display FIFO words held
//   cam_vsync      1-cycle camera frame-start pulse (already synchronised)
//   vga_vsync      1-cycle display frame-start pulse (already synchronised)
//   cmd            command port to the SDRAM controller (master modport)
//   wr_fifo_flush  1-cycle pulse: discard camera FIFO contents
//   rd_bank        bank currently being displayed
//   busy           high while in REQ or WAIT
module frame_buffer_arbiter #(
  parameter int unsigned LVL_W       = 10,
  parameter int unsigned RD_DEPTH    = 512,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned RD_LOW      = 128,
  parameter int unsigned OFFS_W      = 20,
  parameter int unsigned FRAME_WORDS = 737280
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [LVL_W-1:0]     wr_fifo_level,
  input  logic [LVL_W-1:0]     rd_fifo_level,
  input  logic                 cam_vsync,
  input  logic                 vga_vsync,
  frame_buffer_arbiter_if.master cmd,
  output logic                 wr_fifo_flush,
  output logic                 rd_bank,
  output logic                 busy
);

  localparam logic [LVL_W-1:0]  BurstLvl  = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  RdLowLvl  = LVL_W'(RD_LOW);
  localparam logic [LVL_W-1:0]  RdRoomLvl = LVL_W'(RD_DEPTH - BURST_LEN);
  localparam logic [OFFS_W-1:0] FrameEnd  = OFFS_W'(FRAME_WORDS);
  localparam logic [OFFS_W-1:0] BurstOffs = OFFS_W'(BURST_LEN);
  localparam logic [7:0]        CmdLen    = 8'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q;
  logic                wr_bank_q, done_bank_q, rd_bank_q;
  logic [OFFS_W-1:0]   wr_offs_q, rd_offs_q;
  logic                last_grant_q;  // 1 = write, 0 = read
  logic                cam_pend_q, vga_pend_q;
  logic                cmd_req_q, cmd_wr_q, flush_q, busy_q;
  logic [OFFS_W:0]     cmd_addr_q;

  logic                elig_rdu, elig_wr, elig_rd, any_elig, grant_wr;
  logic                apply, wr_frame_done, done_bank_nxt;

  always_comb begin
    elig_rdu      = (rd_fifo_level < RdLowLvl) && (rd_offs_q < FrameEnd);
    elig_wr       = (wr_fifo_level >= BurstLvl) && (wr_offs_q < FrameEnd);
    elig_rd       = (rd_fifo_level <= RdRoomLvl) && (rd_offs_q < FrameEnd);
    any_elig      = elig_rdu || elig_wr || elig_rd;
    grant_wr      = 1'b0;
    if (elig_rdu) begin
      grant_wr = 1'b0;
    end else if (elig_wr && elig_rd) begin
      grant_wr = ~last_grant_q;  // round-robin: opposite of the previous grant
    end else begin
      grant_wr = elig_wr;
    end
    // vsyncs are only applied between bursts, never while one is in flight
    apply         = (state_q == StIdle) && (cam_pend_q || vga_pend_q);
    wr_frame_done = (wr_offs_q == FrameEnd);
    // vga sees the bank that a simultaneous cam vsync has just completed
    done_bank_nxt = (cam_pend_q && wr_frame_done) ? wr_bank_q : done_bank_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= StIdle;
      wr_bank_q    <= 1'b0;
      done_bank_q  <= 1'b1;
      rd_bank_q    <= 1'b1;
      wr_offs_q    <= '0;
      rd_offs_q    <= '0;
      last_grant_q <= 1'b0;
      cam_pend_q   <= 1'b0;
      vga_pend_q   <= 1'b0;
      cmd_req_q    <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      // a vsync in the same cycle as its application re-arms the flag
      cam_pend_q <= cam_vsync || (cam_pend_q && !apply);
      vga_pend_q <= vga_vsync || (vga_pend_q && !apply);
      unique case (state_q)
        StIdle: begin
          if (apply) begin
            if (cam_pend_q) begin
              if (wr_frame_done) begin
                done_bank_q <= wr_bank_q;
                wr_bank_q   <= ~wr_bank_q;
              end
              // a partial frame is simply rewritten in the same bank
              wr_offs_q <= '0;
              flush_q   <= 1'b1;
            end
            if (vga_pend_q) begin
              rd_bank_q <= done_bank_nxt;
              rd_offs_q <= '0;
            end
          end else if (any_elig) begin
            state_q      <= StReq;
            cmd_req_q    <= 1'b1;
            busy_q       <= 1'b1;
            cmd_wr_q     <= grant_wr;
            cmd_addr_q   <= grant_wr ? {wr_bank_q, wr_offs_q} : {rd_bank_q, rd_offs_q};
            last_grant_q <= grant_wr;
          end
        end
        StReq: begin
          if (cmd.cmd_ack) begin
            state_q   <= StWait;
            cmd_req_q <= 1'b0;
          end
        end
        StWait: begin
          if (cmd.burst_done) begin
            if (cmd_wr_q) begin
              wr_offs_q <= wr_offs_q + BurstOffs;
            end else begin
              rd_offs_q <= rd_offs_q + BurstOffs;
            end
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_req   = cmd_req_q;
  assign cmd.cmd_wr    = cmd_wr_q;
  assign cmd.cmd_addr  = cmd_addr_q;
  assign cmd.cmd_len   = CmdLen;
  assign wr_fifo_flush = flush_q;
  assign rd_bank       = rd_bank_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter. Inputs change on the falling edge, outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_frame_buffer_arbiter;

  localparam int unsigned FrameWords = 737280;
  localparam int unsigned BankBit    = 32'h0010_0000;  // bank bit of the 21-bit address

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [9:0] wr_fifo_level, rd_fifo_level;
  logic       cam_vsync, vga_vsync;
  logic       wr_fifo_flush, rd_bank, busy;

  frame_buffer_arbiter_if #(.OFFS_W(20)) cmd_bus ();

  frame_buffer_arbiter dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .wr_fifo_level (wr_fifo_level),
    .rd_fifo_level (rd_fifo_level),
    .cam_vsync     (cam_vsync),
    .vga_vsync     (vga_vsync),
    .cmd           (cmd_bus),
    .wr_fifo_flush (wr_fifo_flush),
    .rd_bank       (rd_bank),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int stable_err, accept_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reset, then release RSTn just after a rising edge; returns at the falling edge of the
  // first post-reset cycle (the one in which IDLE evaluates).
  task automatic do_reset(input logic [9:0] wr_lvl, input logic [9:0] rd_lvl);
    RSTn                = 1'b0;
    cmd_bus.cmd_ack     = 1'b0;
    cmd_bus.burst_done  = 1'b0;
    cam_vsync           = 1'b0;
    vga_vsync           = 1'b0;
    wr_fifo_level       = wr_lvl;
    rd_fifo_level       = rd_lvl;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
  endtask

  // Serve one burst as the SDRAM controller: wait for cmd_req, hold ack low ack_delay cycles,
  // ack, stay in WAIT done_delay cycles, then pulse burst_done.
  task automatic run_burst(input int ack_delay, input int done_delay,
                           output logic got_wr, output logic [20:0] got_addr, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    got_wr = 1'bx;
    got_addr = 'x;
    while (cmd_bus.cmd_req !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (cmd_bus.cmd_req !== 1'b1) return;
    got_wr   = cmd_bus.cmd_wr;
    got_addr = cmd_bus.cmd_addr;
    repeat (ack_delay) begin
      @(negedge CLK);
      if (cmd_bus.cmd_req !== 1'b1 || cmd_bus.cmd_wr !== got_wr || cmd_bus.cmd_addr !== got_addr)
        stable_err++;
    end
    cmd_bus.cmd_ack = 1'b1;
    @(negedge CLK);
    cmd_bus.cmd_ack = 1'b0;
    repeat (done_delay) begin
      if (cmd_bus.cmd_req !== 1'b0 || busy !== 1'b1) accept_err++;
      @(negedge CLK);
    end
    cmd_bus.burst_done = 1'b1;
    @(negedge CLK);
    cmd_bus.burst_done = 1'b0;
    ok = 1'b1;
  endtask

  logic        b_wr;
  logic [20:0] b_addr;
  bit          b_ok;
  int          bad, cnt;
  logic [31:0] exp_addr2 [4];
  logic        exp_wr2   [4];

  initial begin
    cmd_bus.cmd_ack    = 1'b0;
    cmd_bus.burst_done = 1'b0;
    cam_vsync          = 1'b0;
    vga_vsync          = 1'b0;
    wr_fifo_level      = 10'd64;
    rd_fifo_level      = 10'd400;

    // 1. reset values, then first grant: both eligible, last_grant=RD -> write at {0,0}
    repeat (3) @(negedge CLK);
    check_eq("rst_cmd_req", 32'(cmd_bus.cmd_req), 0);
    check_eq("rst_cmd_wr", 32'(cmd_bus.cmd_wr), 0);
    check_eq("rst_cmd_addr", 32'(cmd_bus.cmd_addr), 0);
    check_eq("rst_cmd_len", 32'(cmd_bus.cmd_len), 64);
    check_eq("rst_flush", 32'(wr_fifo_flush), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rd_bank", 32'(rd_bank), 1);
    check_eq("rst_wr_bank", 32'(dut.wr_bank_q), 0);
    check_eq("rst_done_bank", 32'(dut.done_bank_q), 1);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    check_eq("t1_req_cycle1", 32'(cmd_bus.cmd_req), 0);
    @(negedge CLK);
    check_eq("t1_req_cycle2", 32'(cmd_bus.cmd_req), 1);
    check_eq("t1_cmd_wr", 32'(cmd_bus.cmd_wr), 1);
    check_eq("t1_cmd_addr", 32'(cmd_bus.cmd_addr), 0);
    check_eq("t1_busy", 32'(busy), 1);

    // 2. urgent read first, then round-robin; display FIFO gains 64 words per read burst
    exp_wr2   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_addr2 = '{BankBit, 32'd0, BankBit + 32'd64, 32'd64};
    do_reset(10'd64, 10'd100);
    for (int i = 0; i < 4; i++) begin
      run_burst(0, 1, b_wr, b_addr, b_ok);
      check_eq($sformatf("t2_ok_%0d", i), 32'(b_ok), 1);
      check_eq($sformatf("t2_wr_%0d", i), 32'(b_wr), 32'(exp_wr2[i]));
      check_eq($sformatf("t2_addr_%0d", i), 32'(b_addr), exp_addr2[i]);
      if (b_wr === 1'b0) rd_fifo_level = rd_fifo_level + 10'd64;
    end

    // 3. ack held low 10 cycles: command stable, accepted once
    rd_fifo_level = 10'd500;
    stable_err = 0;
    accept_err = 0;
    run_burst(10, 3, b_wr, b_addr, b_ok);
    check_eq("t3_ok", 32'(b_ok), 1);
    check_eq("t3_wr", 32'(b_wr), 1);
    check_eq("t3_addr", 32'(b_addr), 128);
    check_eq("t3_stable_err", 32'(stable_err), 0);
    check_eq("t3_accept_err", 32'(accept_err), 0);

    // 4. one read in bank 1, a full frame of writes, cam vsync swaps banks, vga follows
    do_reset(10'd0, 10'd400);
    run_burst(0, 0, b_wr, b_addr, b_ok);
    check_eq("t4_pre_rd_wr", 32'(b_wr), 0);
    check_eq("t4_pre_rd_addr", 32'(b_addr), BankBit);
    rd_fifo_level = 10'd500;
    wr_fifo_level = 10'd64;
    bad = 0;
    for (int i = 0; i < 11520; i++) begin
      run_burst(0, 0, b_wr, b_addr, b_ok);
      if (!b_ok) begin
        bad++;
        break;
      end
      if (b_wr !== 1'b1 || 32'(b_addr) !== 32'(i * 64)) bad++;
    end
    check_eq("t4_frame_writes_bad", 32'(bad), 0);
    check_eq("t4_wr_offs_full", 32'(dut.wr_offs_q), FrameWords);
    cnt = 0;
    repeat (4) begin
      @(negedge CLK);
      if (cmd_bus.cmd_req === 1'b1) cnt++;
    end
    check_eq("t4_blocked_no_req", 32'(cnt), 0);
    wr_fifo_level = 10'd0;
    cam_vsync = 1'b1;
    @(negedge CLK);
    cam_vsync = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (wr_fifo_flush === 1'b1) cnt++;
    end
    check_eq("t4_flush_pulses", 32'(cnt), 1);
    check_eq("t4_wr_bank", 32'(dut.wr_bank_q), 1);
    check_eq("t4_done_bank", 32'(dut.done_bank_q), 0);
    check_eq("t4_wr_offs", 32'(dut.wr_offs_q), 0);
    check_eq("t4_rd_bank_before", 32'(rd_bank), 1);
    vga_vsync = 1'b1;
    @(negedge CLK);
    vga_vsync = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("t4_rd_bank_after", 32'(rd_bank), 0);
    rd_fifo_level = 10'd400;
    run_burst(0, 0, b_wr, b_addr, b_ok);
    check_eq("t4_post_rd_ok", 32'(b_ok), 1);
    check_eq("t4_post_rd_wr", 32'(b_wr), 0);
    check_eq("t4_post_rd_addr", 32'(b_addr), 0);

    // 5. cam vsync during WAIT on a partial frame (wr_offs reaches 640)
    do_reset(10'd64, 10'd500);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      run_burst(0, 0, b_wr, b_addr, b_ok);
      if (!b_ok || b_wr !== 1'b1 || 32'(b_addr) !== 32'(i * 64)) bad++;
    end
    check_eq("t5_writes_bad", 32'(bad), 0);
    cnt = 0;
    while (cmd_bus.cmd_req !== 1'b1 && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    check_eq("t5_req", 32'(cmd_bus.cmd_req), 1);
    check_eq("t5_addr", 32'(cmd_bus.cmd_addr), 576);
    cmd_bus.cmd_ack = 1'b1;
    @(negedge CLK);
    cmd_bus.cmd_ack = 1'b0;
    cam_vsync = 1'b1;
    @(negedge CLK);
    cam_vsync = 1'b0;
    check_eq("t5_wait_offs", 32'(dut.wr_offs_q), 576);
    check_eq("t5_wait_flush", 32'(wr_fifo_flush), 0);
    cmd_bus.burst_done = 1'b1;
    @(negedge CLK);
    cmd_bus.burst_done = 1'b0;
    check_eq("t5_done_offs", 32'(dut.wr_offs_q), 640);
    check_eq("t5_done_flush", 32'(wr_fifo_flush), 0);
    @(negedge CLK);
    check_eq("t5_apply_offs", 32'(dut.wr_offs_q), 0);
    check_eq("t5_apply_flush", 32'(wr_fifo_flush), 1);
    check_eq("t5_apply_wr_bank", 32'(dut.wr_bank_q), 0);
    check_eq("t5_apply_done_bank", 32'(dut.done_bank_q), 1);

    // 6. asynchronous reset mid-burst, stray burst_done afterwards
    do_reset(10'd64, 10'd500);
    run_burst(0, 0, b_wr, b_addr, b_ok);  // offsets now 64; next burst left in WAIT
    cnt = 0;
    while (cmd_bus.cmd_req !== 1'b1 && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    cmd_bus.cmd_ack = 1'b1;
    @(negedge CLK);
    cmd_bus.cmd_ack = 1'b0;
    check_eq("t6_busy_wait", 32'(busy), 1);
    check_eq("t6_offs_before", 32'(dut.wr_offs_q), 64);
    #2 RSTn = 1'b0;
    #1;
    check_eq("t6_async_busy", 32'(busy), 0);
    check_eq("t6_async_req", 32'(cmd_bus.cmd_req), 0);
    check_eq("t6_async_offs", 32'(dut.wr_offs_q), 0);
    wr_fifo_level = 10'd0;
    @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    cmd_bus.burst_done = 1'b1;
    @(negedge CLK);
    cmd_bus.burst_done = 1'b0;
    @(negedge CLK);
    check_eq("t6_stray_wr_offs", 32'(dut.wr_offs_q), 0);
    check_eq("t6_stray_rd_offs", 32'(dut.rd_offs_q), 0);
    check_eq("t6_stray_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
